// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types and limits for the seven-segment scan controller
package sevenseg_pkg;
  localparam int MAX_DIGITS = 8;
  typedef logic [3:0] nibble_t;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} scan_state_t;
endpackage

// File: rtl/sevenseg_slot_timer.sv
// sevenseg_slot_timer: per-slot cycle counter with blank-end and slot-end strobes
module sevenseg_slot_timer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic blank_done_o,
  output logic slot_done_o
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign blank_done_o = r_cnt == CW'(BLANK_CYCLES - 1);
  assign slot_done_o  = r_cnt == CW'(SCAN_DIV - 1);
  // count through the slot, restarting at every slot start or while idle
  always_ff @(posedge clk_i)
    if (rst_i || !run_i || slot_done_o) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed 7-seg scanner with frame-aligned word loads; SEVENSEG_LZB_EN enables leading-zero blanking
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic                    load_ready_o,
  output nibble_t                 bin_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    dp_o,
  output logic                    frame_o
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  scan_state_t             r_state, w_state_nx;
  logic [IW-1:0]           r_idx, w_idx_nx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val, r_pend_val, w_shadow_val_nx;
  logic [NUM_DIGITS-1:0]   r_shadow_dp, r_pend_dp, w_shadow_dp_nx, w_keep, w_sel_nx;
  logic                    r_pend_valid, w_load, w_xfer, w_frame, w_show;
  logic                    w_blank_done, w_slot_done;
  nibble_t                 w_bin_nx;

  sevenseg_slot_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (enable_i && r_state != S_IDLE),
    .blank_done_o (w_blank_done),
    .slot_done_o  (w_slot_done)
  );

  // next state and digit index; a frame ends when the last digit's slot expires
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_frame    = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nx = enable_i ? S_BLANK : S_IDLE;
      S_BLANK: w_state_nx = !enable_i ? S_IDLE : (w_blank_done ? S_SHOW : S_BLANK);
      S_SHOW: begin
        if (!enable_i) w_state_nx = S_IDLE;
        else if (w_slot_done) begin
          w_state_nx = S_BLANK;
          w_frame    = r_idx == IW'(NUM_DIGITS - 1);
          w_idx_nx   = w_frame ? '0 : r_idx + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_state_nx == S_IDLE) w_idx_nx = '0;
  end

  assign w_load          = load_i && !r_pend_valid;
  assign w_xfer          = r_pend_valid && (w_frame || r_state == S_IDLE);
  assign w_shadow_val_nx = w_xfer ? r_pend_val : r_shadow_val;
  assign w_shadow_dp_nx  = w_xfer ? r_pend_dp : r_shadow_dp;
  assign load_ready_o    = ~r_pend_valid;

  // digits allowed to light; with blanking, a digit stays dark while it and all higher nibbles are zero
  always_comb begin
    w_keep = '1;
`ifdef SEVENSEG_LZB_EN
    for (int k = 1; k < NUM_DIGITS; k++) w_keep[k] = (w_shadow_val_nx >> (4 * k)) != '0;
`endif
  end

  assign w_show   = w_state_nx == S_SHOW;
  assign w_sel_nx = w_show ? (NUM_DIGITS'(1) << w_idx_nx) & w_keep : '0;
  assign w_bin_nx = (w_state_nx == S_IDLE) ? '0 : w_shadow_val_nx[4*w_idx_nx +: 4];

  // state, index, shadow/pending words and registered outputs derived from the next state
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      bin_o        <= '0;
      digit_sel_o  <= '0;
      dp_o         <= 1'b0;
      frame_o      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_shadow_val <= w_shadow_val_nx;
      r_shadow_dp  <= w_shadow_dp_nx;
      r_pend_val   <= w_load ? value_i : r_pend_val;
      r_pend_dp    <= w_load ? dp_i : r_pend_dp;
      r_pend_valid <= w_load || (r_pend_valid && !w_xfer);
      bin_o        <= w_bin_nx;
      digit_sel_o  <= w_sel_nx;
      dp_o         <= w_show && w_shadow_dp_nx[w_idx_nx] && w_keep[w_idx_nx];
      frame_o      <= w_frame;
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-select seven-segment digits that share one sevenseg decoder.
- Holds a display word and steps one nibble at a time into the shared decoder's bin_i.
- Drives a one-hot digit select with a blanking gap between digits to suppress ghosting.
- Accepts new display words through a ready/valid load port, applied only at frame boundaries so a frame never tears.
- Sits between the application logic and the sevenseg decoder plus board pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits. Range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot, blank plus show. Minimum 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all selects off. Range 1..SCAN_DIV-1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  scanning enable.
- load_i  in  1  load valid; the word is captured when load_i and load_ready_o are both high.
- value_i  in  4*NUM_DIGITS  display word; nibble k goes to digit k, nibble 0 in the LSBs.
- dp_i  in  NUM_DIGITS  decimal points, captured together with value_i.
- load_ready_o  out  1  pending buffer empty.
- bin_o  out  4  nibble for the shared decoder.
- digit_sel_o  out  NUM_DIGITS  one-hot active-high digit select.
- dp_o  out  1  decimal point for the current digit, gated like digit_sel_o.
- frame_o  out  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Reset (rst_i high at an edge): state S_IDLE; digit index 0; slot counter 0; shadow word 0; pending buffer empty. Output values: bin_o=0, digit_sel_o=0, dp_o=0, frame_o=0, load_ready_o=1.
- All outputs are registered except load_ready_o, which is ~pending_valid.
- States:
  - S_IDLE: selects off, bin_o=0.
  - S_BLANK: selects off, bin_o = shadow nibble of the current index.
  - S_SHOW: digit_sel_o[index]=1, dp_o = shadow dp[index].
- Transitions:
  - S_IDLE -> S_BLANK (index 0, counter 0) on the cycle after enable_i is sampled high.
  - S_BLANK -> S_SHOW when the counter reaches BLANK_CYCLES-1.
  - S_SHOW -> S_BLANK when the counter reaches SCAN_DIV-1; index increments and wraps NUM_DIGITS-1 -> 0.
- Counter: 0..SCAN_DIV-1, width $clog2(SCAN_DIV), cleared at every slot start.
- Frame boundary = the S_SHOW -> S_BLANK transition out of index NUM_DIGITS-1. On that transition:
  - frame_o is high for exactly one cycle, concurrent with the first S_BLANK cycle of digit 0.
  - If the pending buffer is full, it is copied to the shadow word and emptied on the same edge.
  - The new shadow value is visible from digit 0 of the new frame.
- Load handshake:
  - Capture happens on any edge where load_i && load_ready_o.
  - load_i while load_ready_o=0 is ignored; no overwrite, no error.
- Simultaneous load and frame-boundary transfer: the transfer empties the buffer and the new load refills it. The new word applies at the next boundary.
- In S_IDLE, a full pending buffer transfers on the next edge, so ready returns one cycle after capture.
- enable_i low in any state: S_IDLE on the next edge, selects off, index and counter cleared. Re-enable restarts at digit 0 blank.
- rst_i mid-frame: immediate full reset as above; any pending word is discarded.

Optional Feature:
- SEVENSEG_LZB_EN: leading-zero blanking.
- When defined, during S_SHOW digit_sel_o and dp_o are forced low for every digit k where nibbles k..NUM_DIGITS-1 of the shadow word are all zero. Digit 0 is never blanked.
- Timing is unchanged with the feature enabled.
- When undefined, every digit is shown.

Decomposition:
- Package sevenseg_pkg holds:
  - typedef scan_state_t enum {S_IDLE, S_BLANK, S_SHOW}
  - typedef nibble_t logic [3:0]
  - localparam MAX_DIGITS = 8
- Sub-module sevenseg_slot_timer: slot counter producing blank_done and slot_done strobes, parameterised by SCAN_DIV and BLANK_CYCLES.
- The sevenseg decoder is instantiated at board top, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset, enable_i=0, load 0x1234 -> load_ready_o is 0 for one cycle, then 1; enable_i=1 -> slot 0 shows bin_o=4 with digit_sel_o=0000 for 2 cycles, then 0001 for 6 cycles; bin_o=3 on sel 0010, 2 on 0100, 1 on 1000; frame_o pulses 32 cycles after the first S_BLANK cycle.
2. Scanning 0x1234, load 0xABCD mid-digit-1 -> load_ready_o=0 until the frame boundary; rest of the frame still shows 2 and 1; next frame shows D, C, B, A; ready=1 on the boundary edge.
3. Pending full, load_i pulses with 0x5555 -> ignored; after the boundary the displayed word is the earlier pending word.
4. enable_i dropped during S_SHOW of digit 2 -> next cycle digit_sel_o=0000, bin_o=0; re-enable -> digit 0 blank; rst_i mid-frame with a pending word -> all outputs 0, ready=1, shadow=0.
5. SEVENSEG_LZB_EN defined, value 0x0050 -> digits 0 and 1 selected, digits 2 and 3 sel=0 during their show slots; value 0x0000 -> only digit 0 shown.
